// File: rtl/unified_mem_arbiter_pkg.sv
// Shared arbiter encodings: FSM states, owner codes, fetch access size and watchdog error word.
// Pure definitions; no logic, latency or flow control of its own.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_owner_e;

  // dm_ctrl code for a full 32-bit word; every fetch uses it.
  localparam logic [2:0]  ARB_DM_WORD  = 3'b000;
  localparam logic [31:0] ARB_ERR_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/unified_mem_arbiter_streak.sv
// arb_streak_counter: counts consecutive data grants taken while a fetch waits, saturating at MAX_D_BURST.
// Updates one cycle after inc/clr; clr wins over inc; no backpressure.
module arb_streak_counter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX_D_BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CW'(MAX_D_BURST))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == CW'(MAX_D_BURST));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch and data ports; data wins, fetch starvation bounded by MAX_D_BURST.
// Latency req->ready = 2 + ack wait cycles; requesters stall until ready; ARB_TIMEOUT_EN adds the ack watchdog.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_ctrl,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_ctrl,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          bus_err
);

  if (MAX_D_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("unified_mem_arbiter: MAX_D_BURST and TIMEOUT must be >= 1");
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    ctrl;
  } cmd_t;

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  cmd_t          cmd_q, cmd_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d, rsp_dat;
  logic          grant, grant_d_sel, streak_sat, streak_inc, streak_clr;
  logic          timeout_hit, finish;

  assign grant       = (state_q == ARB_IDLE) && (if_req || d_req);
  assign grant_d_sel = d_req && !(if_req && streak_sat);
  assign streak_inc  = grant && grant_d_sel && if_req;
  // Any IF grant, or a D grant nobody was waiting behind, ends the streak.
  assign streak_clr  = grant && !(grant_d_sel && if_req);

  arb_streak_counter #(.MAX_D_BURST(MAX_D_BURST)) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (streak_inc),
    .clr (streak_clr),
    .sat (streak_sat)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          bus_err_q, bus_err_d;

  always_comb begin
    timer_d     = (state_q == ARB_BUSY) ? timer_q + 1'b1 : '0;
    timeout_hit = (state_q == ARB_BUSY) && !mem_ack && (timer_q == TW'(TIMEOUT - 1));
    bus_err_d   = bus_err_q | timeout_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign finish  = (state_q == ARB_BUSY) && (mem_ack || timeout_hit);
  assign rsp_dat = mem_ack ? mem_rdata : DW'(ARB_ERR_WORD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= ARB_OWN_IF;
      cmd_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cmd_q      <= cmd_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant)  state_d = ARB_BUSY;
      ARB_BUSY: if (finish) state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    cmd_d      = cmd_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (grant) begin
      owner_d = grant_d_sel ? ARB_OWN_D : ARB_OWN_IF;
      cmd_d   = grant_d_sel ? '{we: d_we, addr: d_addr, wdata: d_wdata, ctrl: d_ctrl}
                            : '{we: 1'b0, addr: if_addr, wdata: '0, ctrl: ARB_DM_WORD};
    end
    if (finish) begin
      if (owner_q == ARB_OWN_D) d_rdata_d  = rsp_dat;
      else                      if_rdata_d = rsp_dat;
    end
  end

  always_comb begin
    mem_req   = (state_q == ARB_BUSY);
    if_ready  = (state_q == ARB_DONE) && (owner_q == ARB_OWN_IF);
    d_ready   = (state_q == ARB_DONE) && (owner_q == ARB_OWN_D);
    // Gated by rst so the stalls also collapse the instant reset asserts.
    stall_if  = rst && if_req && !if_ready;
    stall_mem = rst && d_req && !d_ready;
  end

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_ctrl  = cmd_q.ctrl;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed fetch/data traffic, expected issues and responses queued.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata;
  logic [2:0]  d_ctrl = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, stall_if, stall_mem, bus_err;
  logic [2:0]  mem_ctrl;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ctrl(d_ctrl),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  typedef struct { logic is_d; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] ctrl; } iss_t;
  typedef struct { logic is_d; logic [31:0] rdata; } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   checks = 0, failures = 0;
  int   iss_cnt = 0, rdy_cnt = 0;
  int   ack_delay = 0;
  bit   ack_en = 1'b1;
  int   lat_if, lat_d, stall_err, iss0, rdy0, seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_iss(input logic is_d, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] c);
    iss_t e;
    e.is_d = is_d; e.we = we; e.addr = a; e.wdata = wd; e.ctrl = c;
    iss_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic is_d, input logic [31:0] rd);
    rsp_t r;
    r.is_d = is_d; r.rdata = rd;
    rsp_q.push_back(r);
  endtask

  // Memory model: ack after ack_delay wait cycles, read data = addr + 0x1000_0000.
  initial begin
    int w;
    w = 0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_en) begin
        if (w >= ack_delay) begin
          mem_ack = 1'b1; mem_rdata = mem_addr + 32'h1000_0000;
        end else begin
          mem_ack = 1'b0; w++;
        end
      end else begin
        mem_ack = 1'b0; w = 0;
      end
    end
  end

  // Monitor: checks every newly issued transaction and every ready pulse against the queues.
  initial begin
    logic prev;
    iss_t e;
    rsp_t r;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev) begin
        iss_cnt++;
        if (iss_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_issue: got addr %h expected none", mem_addr);
        end else begin
          e = iss_q.pop_front();
          chk("iss_addr", mem_addr, e.addr);
          chk("iss_we", 32'(mem_we), 32'(e.we));
          chk("iss_ctrl", 32'(mem_ctrl), 32'(e.ctrl));
          if (e.we) chk("iss_wdata", mem_wdata, e.wdata);
        end
      end
      prev = mem_req;
      if (if_ready || d_ready) begin
        rdy_cnt++;
        if (rsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ready: got if=%0b d=%0b expected none", if_ready, d_ready);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_src", {30'd0, d_ready, if_ready}, r.is_d ? 32'd2 : 32'd1);
          chk("rsp_rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output int lat, output int serr);
    if_addr = a; if_req = 1'b1; lat = -1; serr = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (if_ready) begin
        lat = n;
        if (stall_if !== 1'b0) serr++;
        break;
      end
      if (stall_if !== 1'b1) serr++;
      @(posedge clk);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dxfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] c, output int lat);
    d_we = we; d_addr = a; d_wdata = wd; d_ctrl = c; d_req = 1'b1; lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (d_ready) begin lat = n; break; end
      @(posedge clk);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // Back-to-back loads with d_req never dropped between them.
  task automatic dburst(input logic [31:0] base, input int cnt);
    d_we = 1'b0; d_ctrl = 3'b001; d_req = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      d_addr = base + 32'(4 * k);
      for (int n = 0; n < 60; n++) begin
        @(negedge clk);
        if (d_ready) break;
        @(posedge clk);
      end
      @(posedge clk); #1;
    end
    d_req = 1'b0;
  endtask

  initial begin
    // Reset state, with requests asserted to show stalls are held low too.
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_stall", {30'd0, stall_if, stall_mem}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // 1: lone fetch, ack one cycle after mem_req.
    ack_delay = 1;
    exp_iss(1'b0, 1'b0, 32'h40, 32'h0, 3'b000);
    exp_rsp(1'b0, 32'h1000_0040);
    fetch(32'h40, lat_if, stall_err);
    chk("t1_latency", 32'(lat_if), 32'd3);
    chk("t1_stall_if", 32'(stall_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_rdata_hold", if_rdata, 32'h1000_0040);
    @(posedge clk); #1;

    // 2: simultaneous store and fetch; store goes first.
    ack_delay = 0;
    exp_iss(1'b1, 1'b1, 32'h100, 32'h1234, 3'b010);
    exp_iss(1'b0, 1'b0, 32'h200, 32'h0, 3'b000);
    exp_rsp(1'b1, 32'h1000_0100);
    exp_rsp(1'b0, 32'h1000_0200);
    fork
      fetch(32'h200, lat_if, stall_err);
      dxfer(1'b1, 32'h100, 32'h1234, 3'b010, lat_d);
    join
    chk("t2_d_latency", 32'(lat_d), 32'd2);
    chk("t2_if_latency", 32'(lat_if), 32'd5);
    chk("t2_stall_if", 32'(stall_err), 32'd0);

    // 3: continuous data stream: 4 D grants, then the fetch, then the rest.
    for (int k = 0; k < 4; k++) begin
      exp_iss(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h0, 3'b001);
      exp_rsp(1'b1, 32'h1000_0400 + 32'(4 * k));
    end
    exp_iss(1'b0, 1'b0, 32'h300, 32'h0, 3'b000);
    exp_rsp(1'b0, 32'h1000_0300);
    for (int k = 4; k < 6; k++) begin
      exp_iss(1'b1, 1'b0, 32'h400 + 32'(4 * k), 32'h0, 3'b001);
      exp_rsp(1'b1, 32'h1000_0400 + 32'(4 * k));
    end
    fork
      fetch(32'h300, lat_if, stall_err);
      dburst(32'h400, 6);
    join
    chk("t3_if_latency", 32'(lat_if), 32'd14);
    chk("t3_stall_if", 32'(stall_err), 32'd0);

    // 4: req still high in the DONE cycle must not re-issue.
    ack_delay = 2;
    iss0 = iss_cnt; rdy0 = rdy_cnt;
    exp_iss(1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
    exp_rsp(1'b1, 32'h1000_0500);
    dxfer(1'b0, 32'h500, 32'h0, 3'b000, lat_d);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_latency", 32'(lat_d), 32'd4);
    chk("t4_issue_count", 32'(iss_cnt - iss0), 32'd1);
    chk("t4_ready_count", 32'(rdy_cnt - rdy0), 32'd1);
    @(posedge clk); #1;

    // 5: asynchronous reset in the middle of a transaction.
    ack_en = 1'b0;
    exp_iss(1'b0, 1'b0, 32'h800, 32'h0, 3'b000);
    if_addr = 32'h800; if_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_busy_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_mem_req", 32'(mem_req), 32'd0);
    chk("t5_async_stall", {30'd0, stall_if, stall_mem}, 32'd0);
    chk("t5_async_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("t5_async_rdata", if_rdata | d_rdata, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    ack_en = 1'b1; ack_delay = 0;
    @(posedge clk); #1;
    exp_iss(1'b0, 1'b0, 32'h840, 32'h0, 3'b000);
    exp_rsp(1'b0, 32'h1000_0840);
    fetch(32'h840, lat_if, stall_err);
    chk("t5_after_rst_latency", 32'(lat_if), 32'd2);

    // 6: memory never acks.
    ack_en = 1'b0;
    exp_iss(1'b0, 1'b0, 32'hC00, 32'h0, 3'b000);
`ifdef ARB_TIMEOUT_EN
    exp_rsp(1'b0, 32'hDEADBEEF);
    fetch(32'hC00, lat_if, stall_err);
    chk("t6_timeout_latency", 32'(lat_if), 32'd9);
    @(negedge clk);
    chk("t6_bus_err", 32'(bus_err), 32'd1);
    ack_en = 1'b1;
    @(posedge clk); #1;
    exp_iss(1'b0, 1'b0, 32'hC40, 32'h0, 3'b000);
    exp_rsp(1'b0, 32'h1000_0C40);
    fetch(32'hC40, lat_if, stall_err);
    @(negedge clk);
    chk("t6_bus_err_sticky", 32'(bus_err), 32'd1);
`else
    if_addr = 32'hC00; if_req = 1'b1; seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_ready) seen++;
    end
    chk("t6_no_ready", 32'(seen), 32'd0);
    chk("t6_still_busy", 32'(mem_req), 32'd1);
    chk("t6_bus_err_zero", 32'(bus_err), 32'd0);
    #2 rst = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    ack_en = 1'b1;
`endif

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("iss_queue_drained", 32'(iss_q.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
